// File: rtl/i2c_sda_master.sv
// SDA-side transaction engine for one SHT40 measurement: observes SCL, drives open-drain SDA.
// Define I2C_CRC8_CHECK_EN to add the sticky Crc_Err output and CRC-8 checking of every third read byte.
module i2c_sda_master #(
  parameter logic [6:0] DEV_ADDR   = 7'h44,
  parameter logic [7:0] MEAS_CMD   = 8'hFD,
  parameter int         READ_BYTES = 6,
  parameter int         START_HOLD = 10,
  parameter int         MEAS_WAIT  = 450000
) (
  input  logic       clk,
  input  logic       Rst_N,
  input  logic       Start,
  input  logic       Scl_Data,
  inout  wire        Sda_Data,
  output logic [2:0] Master_State_Out,
  output logic       Busy,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Valid,
  output logic       Nack_Err,
`ifdef I2C_CRC8_CHECK_EN
  output logic       Crc_Err,
`endif
  output logic       Done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;

  localparam logic [1:0] STP_DRIVE = 2'd0;
  localparam logic [1:0] STP_WAITH = 2'd1;
  localparam logic [1:0] STP_HOLD  = 2'd2;
  localparam logic [1:0] STP_MEAS  = 2'd3;

  localparam int CNT_MAX = (MEAS_WAIT > START_HOLD) ? MEAS_WAIT : START_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEAS_WAIT - 1);
  localparam logic [3:0]       LAST_BYTE = 4'(READ_BYTES - 1);

  // SDA is synchronised with the same depth as SCL so a sample taken on the
  // detected rise reflects the line as it was when SCL actually rose.
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       scl_rise;
  logic       scl_fall;
  logic       scl_high;
  logic       sda_s;

  logic [2:0]       state_q,        state_d;
  logic             sda_oe_q,       sda_oe_d;
  logic             busy_q,         busy_d;
  logic [7:0]       rx_byte_q,      rx_byte_d;
  logic             rx_valid_q,     rx_valid_d;
  logic             nack_err_q,     nack_err_d;
  logic             done_q,         done_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [7:0]       shift_q,        shift_d;
  logic [2:0]       bit_cnt_q,      bit_cnt_d;
  logic [3:0]       byte_cnt_q,     byte_cnt_d;
  logic             last_bit_q,     last_bit_d;
  logic             rd_phase_q,     rd_phase_d;
  logic             ack_cmd_q,      ack_cmd_d;
  logic             rd_ack_q,       rd_ack_d;
  logic             got8_q,         got8_d;
  logic [1:0]       stop_step_q,    stop_step_d;
  logic             stop_to_rd_q,   stop_to_rd_d;

  logic start_accept;
  logic rx_load;

  assign scl_high = scl_sync_q[1];
  assign scl_rise = scl_sync_q[1] & ~scl_prev_q;
  assign scl_fall = ~scl_sync_q[1] & scl_prev_q;
  assign sda_s    = sda_sync_q[1];

  assign start_accept = (state_q == S_IDLE) && Start;
  assign rx_load      = (state_q == S_READ) && !rd_ack_q && got8_q && scl_fall;

  always_comb begin
    state_d      = state_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = 1'b0;
    nack_err_d   = nack_err_q;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    last_bit_d   = last_bit_q;
    rd_phase_d   = rd_phase_q;
    ack_cmd_d    = ack_cmd_q;
    rd_ack_d     = rd_ack_q;
    got8_d       = got8_q;
    stop_step_d  = stop_step_q;
    stop_to_rd_d = stop_to_rd_q;

    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          state_d    = S_START;
          sda_oe_d   = 1'b1;
          busy_d     = 1'b1;
          nack_err_d = 1'b0;
          cnt_d      = '0;
          rd_phase_d = 1'b0;
          byte_cnt_d = '0;
        end
      end

      S_START: begin
        if (cnt_q == HOLD_LAST) begin
          state_d    = S_ADDR;
          cnt_d      = '0;
          shift_d    = {DEV_ADDR, rd_phase_q};
          bit_cnt_d  = '0;
          last_bit_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ADDR, S_WRITE: begin
        if (scl_fall) begin
          if (last_bit_q) begin
            sda_oe_d  = 1'b0;
            state_d   = S_ACK;
            ack_cmd_d = (state_q == S_WRITE);
          end else begin
            sda_oe_d   = ~shift_q[7];
            shift_d    = {shift_q[6:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            last_bit_d = (bit_cnt_q == 3'd7);
          end
        end
      end

      S_ACK: begin
        if (scl_rise) begin
          if (sda_s) begin
            nack_err_d   = 1'b1;
            state_d      = S_STOP;
            stop_step_d  = STP_DRIVE;
            stop_to_rd_d = 1'b0;
          end else if (rd_phase_q) begin
            state_d   = S_READ;
            bit_cnt_d = '0;
            rd_ack_d  = 1'b0;
            got8_d    = 1'b0;
          end else if (ack_cmd_q) begin
            state_d      = S_STOP;
            stop_step_d  = STP_DRIVE;
            stop_to_rd_d = 1'b1;
          end else begin
            state_d    = S_WRITE;
            shift_d    = MEAS_CMD;
            bit_cnt_d  = '0;
            last_bit_d = 1'b0;
          end
        end
      end

      S_READ: begin
        if (!rd_ack_q) begin
          if (scl_rise && !got8_q) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
            got8_d    = (bit_cnt_q == 3'd7);
          end else if (rx_load) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
            // ACK every byte but the last; the last gets NACK (line released).
            sda_oe_d   = (byte_cnt_q != LAST_BYTE);
            rd_ack_d   = 1'b1;
            got8_d     = 1'b0;
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end else if (scl_rise) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d      = S_STOP;
            stop_step_d  = STP_DRIVE;
            stop_to_rd_d = 1'b0;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            rd_ack_d   = 1'b0;
          end
        end
      end

      S_STOP: begin
        case (stop_step_q)
          STP_DRIVE: begin
            if (scl_fall) begin
              sda_oe_d    = 1'b1;
              stop_step_d = STP_WAITH;
            end
          end
          STP_WAITH: begin
            if (scl_high) begin
              stop_step_d = STP_HOLD;
              cnt_d       = '0;
            end
          end
          STP_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (stop_to_rd_q) begin
                stop_step_d = STP_MEAS;
              end else begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                stop_step_d = STP_DRIVE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            // Sensor conversion time; the read transaction starts afresh afterwards.
            if (cnt_q == WAIT_LAST) begin
              state_d      = S_START;
              sda_oe_d     = 1'b1;
              cnt_d        = '0;
              rd_phase_d   = 1'b1;
              stop_to_rd_d = 1'b0;
              stop_step_d  = STP_DRIVE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end

      default: begin
        state_d  = S_IDLE;
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Rst_N) begin
      scl_sync_q   <= 2'b11;
      sda_sync_q   <= 2'b11;
      scl_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      nack_err_q   <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      last_bit_q   <= 1'b0;
      rd_phase_q   <= 1'b0;
      ack_cmd_q    <= 1'b0;
      rd_ack_q     <= 1'b0;
      got8_q       <= 1'b0;
      stop_step_q  <= STP_DRIVE;
      stop_to_rd_q <= 1'b0;
    end else begin
      scl_sync_q   <= {scl_sync_q[0], Scl_Data};
      sda_sync_q   <= {sda_sync_q[0], Sda_Data};
      scl_prev_q   <= scl_sync_q[1];
      state_q      <= state_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      nack_err_q   <= nack_err_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      last_bit_q   <= last_bit_d;
      rd_phase_q   <= rd_phase_d;
      ack_cmd_q    <= ack_cmd_d;
      rd_ack_q     <= rd_ack_d;
      got8_q       <= got8_d;
      stop_step_q  <= stop_step_d;
      stop_to_rd_q <= stop_to_rd_d;
    end
  end

`ifdef I2C_CRC8_CHECK_EN
  logic [7:0] crc_b0_q, crc_b0_d;
  logic [7:0] crc_b1_q, crc_b1_d;
  logic [1:0] trip_q,   trip_d;
  logic       crc_err_q, crc_err_d;

  function automatic logic [7:0] crc8_pair(input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  c;
    logic [15:0] data;
    c    = 8'hFF;
    data = {a, b};
    for (int i = 15; i >= 0; i--) begin
      c = (c[7] ^ data[i]) ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    crc_b0_d  = crc_b0_q;
    crc_b1_d  = crc_b1_q;
    trip_d    = trip_q;
    crc_err_d = crc_err_q;
    if (start_accept) begin
      trip_d    = '0;
      crc_err_d = 1'b0;
    end else if (rx_load) begin
      if (trip_q == 2'd2) begin
        trip_d = '0;
        if (shift_q != crc8_pair(crc_b0_q, crc_b1_q)) begin
          crc_err_d = 1'b1;
        end
      end else begin
        crc_b0_d = crc_b1_q;
        crc_b1_d = shift_q;
        trip_d   = trip_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst_N) begin
      crc_b0_q  <= '0;
      crc_b1_q  <= '0;
      trip_q    <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_b0_q  <= crc_b0_d;
      crc_b1_q  <= crc_b1_d;
      trip_q    <= trip_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign Crc_Err = crc_err_q;
`endif

  assign Sda_Data         = sda_oe_q ? 1'b0 : 1'bz;
  assign Master_State_Out = state_q;
  assign Busy             = busy_q;
  assign Rx_Byte          = rx_byte_q;
  assign Rx_Valid         = rx_valid_q;
  assign Nack_Err         = nack_err_q;
  assign Done             = done_q;

endmodule
